// File: rtl/sram_like_ram_pkg.sv
// Shared types and helpers for the sram_like responder: bus widths, size codes,
// request capture payload and the size/offset to byte-lane mask function.
package sram_like_ram_pkg;

    localparam int unsigned W_ADDR  = 32;
    localparam int unsigned W_DATA  = 32;
    localparam int unsigned N_LANES = W_DATA / 8;
    localparam int unsigned CNT_W   = 4;

    // Code 2'b11 is a legal alias of a word access.
    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_WORD_X = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              wr;
        size_e             size;
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] wdata;
    } req_t;

    function automatic logic [N_LANES-1:0] lane_mask(input size_e size, input logic [1:0] offset);
        logic [N_LANES-1:0] mask;
        case (size)
            SIZE_BYTE: mask = N_LANES'(1) << offset;
            SIZE_HALF: mask = offset[1] ? N_LANES'(4'b1100) : N_LANES'(4'b0011);
            default:   mask = '1;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sram_like_ram_byte_ram.sv
// Single-port word RAM with per-byte write enables, synchronous write and
// combinational read of the addressed word. Contents are never reset.
module byte_ram
    import sram_like_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [N_LANES-1:0]             be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [W_DATA-1:0]              wdata,
    output logic [W_DATA-1:0]              rdata
);

    logic [N_LANES-1:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(N_LANES); i++) begin
                if (be[i]) begin
                    mem[addr][i] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sram_like_ram.sv
// Responder end of the sram_like protocol: one outstanding request, fixed
// completion latency, backed by a byte-enabled word RAM.
module sram_like_ram
    import sram_like_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sram_like_req,
    input  logic              sram_like_wr,
    input  logic [1:0]        sram_like_size,
    input  logic [W_ADDR-1:0] sram_like_addr,
    input  logic [W_DATA-1:0] sram_like_wdata,
    output logic [W_DATA-1:0] sram_like_rdata,
    output logic              sram_like_addr_ok,
    output logic              sram_like_data_ok
);

    localparam int unsigned    AW         = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

    state_e             state;
    state_e             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    req_t               cap;
    req_t               cap_n;
    logic               data_ok_n;
    logic [W_DATA-1:0]  rdata_n;

    logic               done_c;
    logic               accept_c;
    logic               ram_we;
    logic [N_LANES-1:0] ram_be;
    logic [AW-1:0]      ram_addr;
    logic [W_DATA-1:0]  ram_rdata;
    logic [W_ADDR-AW-3:0] unused_addr_hi;

    // Completion cycle: counter has run out while a request is outstanding.
    assign done_c            = (state == ST_WAIT) && (cnt == '0);
    assign sram_like_addr_ok = sram_like_req && rst && ((state == ST_IDLE) || done_c);
    assign accept_c          = sram_like_addr_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            cap               <= '0;
            sram_like_data_ok <= 1'b0;
            sram_like_rdata   <= '0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            cap               <= cap_n;
            sram_like_data_ok <= data_ok_n;
            sram_like_rdata   <= rdata_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap;
        if (accept_c) begin
            state_n       = ST_WAIT;
            cnt_n         = CNT_RELOAD;
            cap_n.wr      = sram_like_wr;
            cap_n.size    = size_e'(sram_like_size);
            cap_n.addr    = sram_like_addr;
            cap_n.wdata   = sram_like_wdata;
        end else if (done_c) begin
            state_n = ST_IDLE;
        end else if (state == ST_WAIT) begin
            cnt_n = cnt - CNT_W'(1);
        end
    end

    // The edge that opens the completion cycle performs the RAM access, so the
    // registered rdata is already valid while data_ok is high.
    always_comb begin
        data_ok_n = (state_n == ST_WAIT) && (cnt_n == '0);
        rdata_n   = sram_like_rdata;
        ram_we    = 1'b0;
        if (data_ok_n) begin
            if (cap_n.wr) begin
                ram_we = rst;
            end else begin
                rdata_n = ram_rdata;
            end
        end
    end

    assign ram_addr       = cap_n.addr[AW+1:2];
    assign ram_be         = lane_mask(cap_n.size, cap_n.addr[1:0]);
    assign unused_addr_hi = cap_n.addr[W_ADDR-1:AW+2];

    byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (cap_n.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_sram_like_ram.sv
// Bench for sram_like_ram: directed protocol scenarios followed by random
// traffic, all checked against a byte-array memory model.
module tb_sram_like_ram;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl [DEPTH*4];
    logic [31:0] exp_rdata;

    sram_like_ram #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .sram_like_req     (req),
        .sram_like_wr      (wr),
        .sram_like_size    (size),
        .sram_like_addr    (addr),
        .sram_like_wdata   (wdata),
        .sram_like_rdata   (rdata),
        .sram_like_addr_ok (addr_ok),
        .sram_like_data_ok (data_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int w;
        w = int'((a >> 2) % 32'(DEPTH));
        return {mdl[w*4+3], mdl[w*4+2], mdl[w*4+1], mdl[w*4]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int w;
        int off;
        bit hit;
        w   = int'((a >> 2) % 32'(DEPTH));
        off = int'(a[1:0]);
        for (int lane = 0; lane < 4; lane++) begin
            case (s)
                2'd0:    hit = (lane == off);
                2'd1:    hit = (lane / 2 == off / 2);
                default: hit = 1'b1;
            endcase
            if (hit) mdl[w*4+lane] = d[8*lane +: 8];
        end
    endtask

    // One isolated transaction: request accepted at once, completion LAT cycles later.
    task automatic txn(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int          n;
        bit          seen;
        logic [31:0] expect_r;
        @(negedge clk);
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        #1;
        check("addr_ok_on_req", 32'(addr_ok), 32'd1);
        expect_r = w ? exp_rdata : model_word(a);
        @(posedge clk);
        #1;
        req = 1'b0; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(negedge clk);
            n++;
            seen = data_ok;
        end
        check("data_ok_latency", 32'(n), 32'(LAT));
        if (w) model_write(a, s, d);
        else   exp_rdata = expect_r;
        check(w ? "rdata_hold_on_write" : "rdata", rdata, expect_r);
        @(negedge clk);
        check("data_ok_single_pulse", 32'(data_ok), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        bit          exp_aok;
        bit          exp_dok;
        int          idx;

        rst = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; addr = '0; wdata = '0;
        exp_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset_addr_ok", 32'(addr_ok), 32'd0);
        check("reset_data_ok", 32'(data_ok), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_req_data_ok", 32'(data_ok), 32'd0);

        // Word, byte and half writes into one word.
        txn(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        txn(1'b0, 2'd2, 32'h10, 32'h0);
        check("word_readback", rdata, 32'hDEADBEEF);
        txn(1'b1, 2'd0, 32'h11, 32'h0000AA00);
        txn(1'b0, 2'd2, 32'h10, 32'h0);
        check("byte_merge", rdata, 32'hDEADAAEF);
        txn(1'b1, 2'd1, 32'h12, 32'h12340000);
        txn(1'b0, 2'd2, 32'h10, 32'h0);
        check("half_merge", rdata, 32'h1234AAEF);

        // Back-to-back reads with req held high.
        txn(1'b1, 2'd2, 32'h40, 32'h01020304);
        txn(1'b1, 2'd2, 32'h44, 32'hA5A5F0F0);
        txn(1'b1, 2'd2, 32'h48, 32'h77665544);
        for (int k = 0; k <= 3 * LAT + 1; k++) begin
            @(negedge clk);
            idx  = (k / LAT > 2) ? 2 : k / LAT;
            req  = (k < 3 * LAT);
            wr   = 1'b0;
            size = 2'd2;
            addr = 32'h40 + 32'(4 * idx);
            #1;
            exp_aok = (k % LAT == 0) && (k < 3 * LAT);
            exp_dok = (k > 0) && (k % LAT == 0) && (k <= 3 * LAT);
            check("pipe_addr_ok", 32'(addr_ok), 32'(exp_aok));
            check("pipe_data_ok", 32'(data_ok), 32'(exp_dok));
            if (exp_dok) check("pipe_rdata", rdata, model_word(32'h40 + 32'(4 * (k / LAT - 1))));
        end
        req = 1'b0;
        exp_rdata = model_word(32'h48);

        // Address aliasing beyond the RAM depth.
        txn(1'b1, 2'd2, 32'h1000, 32'h55AA55AA);
        txn(1'b0, 2'd2, 32'h0, 32'h0);
        check("alias_wrap", rdata, 32'h55AA55AA);

        // Size 11 behaves as word; byte read returns the full unshifted word.
        txn(1'b1, 2'd3, 32'h30, 32'hCAFEF00D);
        txn(1'b0, 2'd0, 32'h33, 32'h0);
        check("byte_read_full_word", rdata, 32'hCAFEF00D);

        // Reset while a write is outstanding aborts it.
        txn(1'b1, 2'd2, 32'h20, 32'h0BADF00D);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h11111111;
        #1;
        check("abort_accept", 32'(addr_ok), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            check("abort_addr_ok", 32'(addr_ok), 32'd0);
            check("abort_data_ok", 32'(data_ok), 32'd0);
            @(negedge clk);
        end
        check("abort_rdata_reset", rdata, 32'd0);
        rst = 1'b1; req = 1'b0;
        repeat (2) @(negedge clk);
        check("post_abort_idle", 32'(data_ok), 32'd0);
        txn(1'b0, 2'd2, 32'h20, 32'h0);
        check("abort_keeps_old", rdata, 32'h0BADF00D);

        // Random traffic over a 16-word window with aliased upper address bits.
        for (int i = 0; i < 16; i++) txn(1'b1, 2'd2, 32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 80; i++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)));
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
